// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble).
// A start in IDLE loads the operand. WIDTH shift cycles then build the BCD
// digits in a scratch register that is one digit wider than the output.
// The DONE cycle registers bcd/neg/ovf/digit_en and raises a one-cycle done pulse.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  neg_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  ovf,
    output logic [DIGITS-1:0]     digit_en
);

    // Scratch holds DIGITS+1 digits so that out-of-range magnitudes can be detected.
    localparam int SW = 4 * (DIGITS + 1);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]            r_state;
    logic [WIDTH-1:0]      r_shreg;
    logic [SW-1:0]         r_scratch;
    logic [CW-1:0]         r_cnt;
    logic                  r_neg_lat;

    logic                  r_done;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_neg;
    logic                  r_ovf;
    logic [DIGITS-1:0]     r_den;

    logic [4*DIGITS-1:0]   w_adj;
    logic [DIGITS-1:0]     w_nz;
    logic [DIGITS-1:0]     w_den;
    logic                  w_ovf;

    // Apply the add-3 correction to the lower DIGITS scratch digits.
    // The top digit is never >= 5 before a shift while WIDTH <= 3*DIGITS+3,
    // so it is shifted without a correction.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi = gi + 1) begin : g_adj
            assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                      (r_scratch[4*gi +: 4] + 4'd3) :
                                      r_scratch[4*gi +: 4];
        end
    endgenerate

    // Mark each digit as nonzero, then mark it significant when it or any
    // higher digit is nonzero. Digit 0 is always shown.
    generate
        for (gi = 0; gi < DIGITS; gi = gi + 1) begin : g_den
            assign w_nz[gi] = |r_scratch[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign w_den[gi] = 1'b1;
            end else begin : g_upper
                assign w_den[gi] = |w_nz[DIGITS-1:gi];
            end
        end
    endgenerate

    // Any value in the extra top digit means the magnitude does not fit in DIGITS digits.
    assign w_ovf = |r_scratch[SW-1 -: 4];

    // Sequence control and shift datapath: load on start, then shift WIDTH times.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_neg_lat <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shreg   <= bin;
                        r_scratch <= '0;
                        r_cnt     <= CW'(WIDTH);
                        r_neg_lat <= neg_in;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= {r_scratch[SW-2 -: 3], w_adj, r_shreg[WIDTH-1]};
                    r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
                    r_cnt     <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Result registers: update only in DONE and hold between conversions.
    // Saturate to all nines when the result overflows.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_done <= 1'b0;
            r_bcd  <= '0;
            r_neg  <= 1'b0;
            r_ovf  <= 1'b0;
            r_den  <= DIGITS'(1);
        end else begin
            r_done <= 1'b0;
            if (r_state == S_DONE) begin
                r_done <= 1'b1;
                r_neg  <= r_neg_lat;
                r_ovf  <= w_ovf;
                if (w_ovf) begin
                    r_bcd <= {DIGITS{4'h9}};
                    r_den <= '1;
                end else begin
                    r_bcd <= r_scratch[4*DIGITS-1:0];
                    r_den <= w_den;
                end
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign neg      = r_neg;
    assign ovf      = r_ovf;
    assign digit_en = r_den;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq. A behavioural model derives the expected digits
// with decimal arithmetic and the expected timing with an accept/latency countdown.
// A compare process checks the DUT against the model on every falling edge.
// Directed cases also check literal values.
module tb_bin_to_bcd_seq;
    localparam int WIDTH  = 14;
    localparam int DIGITS = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [WIDTH-1:0]  bin = '0;
    logic              neg_in = 1'b0;
    logic              busy;
    logic              done;
    logic [15:0]       bcd;
    logic              neg;
    logic              ovf;
    logic [3:0]        digit_en;

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin), .neg_in(neg_in),
        .busy(busy), .done(done), .bcd(bcd), .neg(neg), .ovf(ovf),
        .digit_en(digit_en)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model state.
    int          m_cnt = 0;
    int          m_accepts = 0;
    int          m_op = 0;
    logic        m_opneg = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_bcd = '0;
    logic        m_neg = 1'b0;
    logic        m_ovf = 1'b0;
    logic [3:0]  m_en = 4'b0001;

    // Decimal reference: digit i = (v / 10^i) % 10; digit i is significant iff v >= 10^i.
    function automatic void ref_conv(input int v, output logic [15:0] b,
                                     output logic o, output logic [3:0] e);
        int p;
        b = '0;
        o = 1'b0;
        e = 4'b0001;
        if (v > 9999) begin
            o = 1'b1;
            b = 16'h9999;
            e = 4'b1111;
        end else begin
            p = 1;
            for (int i = 0; i < 4; i++) begin
                b[4*i +: 4] = 4'((v / p) % 10);
                if (i > 0 && v >= p) e[i] = 1'b1;
                p = p * 10;
            end
        end
    endfunction

    // Model: accepting a start in idle schedules done WIDTH+1 edges later.
    always @(posedge clk) begin
        if (!rst) begin
            m_cnt  = 0;
            m_done = 1'b0;
            m_bcd  = '0;
            m_neg  = 1'b0;
            m_ovf  = 1'b0;
            m_en   = 4'b0001;
        end else begin
            m_done = 1'b0;
            if (m_cnt == 0) begin
                if (start) begin
                    m_op      = int'(bin);
                    m_opneg   = neg_in;
                    m_cnt     = WIDTH + 1;
                    m_accepts = m_accepts + 1;
                end
            end else begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    ref_conv(m_op, m_bcd, m_ovf, m_en);
                    m_neg  = m_opneg;
                    m_done = 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (busy !== (m_cnt != 0) || done !== m_done || bcd !== m_bcd ||
                neg !== m_neg || ovf !== m_ovf || digit_en !== m_en) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got busy=%b done=%b bcd=%h neg=%b ovf=%b en=%b exp busy=%b done=%b bcd=%h neg=%b ovf=%b en=%b",
                         $time, busy, done, bcd, neg, ovf, digit_en,
                         (m_cnt != 0), m_done, m_bcd, m_neg, m_ovf, m_en);
            end
        end
    end

    task automatic check_lit(input string name, input logic [15:0] eb,
                             input logic [3:0] ee, input logic eo, input logic eneg);
        n_vec++;
        if (bcd !== eb || digit_en !== ee || ovf !== eo || neg !== eneg) begin
            n_fail++;
            $display("FAIL %s got bcd=%h en=%b ovf=%b neg=%b exp bcd=%h en=%b ovf=%b neg=%b",
                     name, bcd, digit_en, ovf, neg, eb, ee, eo, eneg);
        end
        $display("txn %s bcd=%h en=%b ovf=%b neg=%b", name, bcd, digit_en, ovf, neg);
    endtask

    // Wait, for a bounded number of cycles, until done is seen at a falling edge.
    // k returns the number of falling edges waited.
    task automatic wait_done(output int k);
        k = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            k = i + 1;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) begin
            n_vec++;
            n_fail++;
            $display("FAIL done_timeout waited=%0d cycles, required done=1", k);
        end
    endtask

    task automatic check_latency(input string name, input int k);
        n_vec++;
        if (k != WIDTH + 2) begin
            n_fail++;
            $display("FAIL %s latency got=%0d required=%0d", name, k, WIDTH + 2);
        end
    endtask

    // Issue a one-cycle start. Afterwards, scramble the operand inputs.
    task automatic start_one(input int v, input logic n);
        @(posedge clk);
        #1;
        start  = 1'b1;
        bin    = WIDTH'(v);
        neg_in = n;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bin    = WIDTH'($urandom);
        neg_in = ~n;
    endtask

    initial begin
        int k;
        int seen;
        int target;
        int cyc;
        int r;

        // Reset.
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_lit("reset", 16'h0000, 4'b0001, 1'b0, 1'b0);

        // Test 1: basic conversion and latency.
        start_one(1234, 1'b0);
        wait_done(k);
        check_latency("t1_latency", k);
        check_lit("t1_1234", 16'h1234, 4'b1111, 1'b0, 1'b0);

        // Test 2: zero, negative zero, and a small negative value.
        start_one(0, 1'b0);
        wait_done(k);
        check_lit("t2_zero", 16'h0000, 4'b0001, 1'b0, 1'b0);
        start_one(0, 1'b1);
        wait_done(k);
        check_lit("t2_neg_zero", 16'h0000, 4'b0001, 1'b0, 1'b1);
        start_one(42, 1'b1);
        wait_done(k);
        check_lit("t2_42", 16'h0042, 4'b0011, 1'b0, 1'b1);
        start_one(305, 1'b0);
        wait_done(k);
        check_lit("t2_305", 16'h0305, 4'b0111, 1'b0, 1'b0);

        // Test 3: overflow boundary.
        start_one(9999, 1'b0);
        wait_done(k);
        check_lit("t3_9999", 16'h9999, 4'b1111, 1'b0, 1'b0);
        start_one(10000, 1'b0);
        wait_done(k);
        check_lit("t3_10000", 16'h9999, 4'b1111, 1'b1, 1'b0);
        start_one(16383, 1'b1);
        wait_done(k);
        check_lit("t3_16383", 16'h9999, 4'b1111, 1'b1, 1'b1);

        // Test 4: a start pulsed while busy is ignored.
        @(posedge clk);
        #1;
        start = 1'b1; bin = WIDTH'(500); neg_in = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0; bin = WIDTH'(7);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(k);
        check_lit("t4_ignored", 16'h0500, 4'b0111, 1'b0, 1'b0);

        // Test 4b: start held high gives back-to-back conversions.
        @(posedge clk);
        #1;
        start = 1'b1; bin = WIDTH'(321); neg_in = 1'b0;
        @(posedge clk);
        #1;
        bin = WIDTH'(654); neg_in = 1'b1;
        wait_done(k);
        check_lit("t4_b2b_first", 16'h0321, 4'b0111, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0; bin = '0;
        wait_done(k);
        check_latency("t4_b2b_latency", k);
        check_lit("t4_b2b_second", 16'h0654, 4'b0111, 1'b0, 1'b1);

        // Test 5: reset in the middle of a conversion aborts it.
        start_one(1234, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_lit("t5_abort", 16'h0000, 4'b0001, 1'b0, 1'b0);
        n_vec++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_abort_busy got=%b required=0", busy);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL t5_no_done got=%0d done pulses required=0", seen);
        end
        $display("txn t5_no_done pulses=%0d", seen);

        // Reset wins over start in the same cycle.
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b1; bin = WIDTH'(99);
        @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_reset_over_start busy got=%b required=0", busy);
        end
        start_one(77, 1'b0);
        wait_done(k);
        check_lit("t5_77", 16'h0077, 4'b0011, 1'b0, 1'b0);

        // Test 6: randomised operands, often back-to-back; the compare process checks every cycle.
        target = m_accepts + 1000;
        cyc = 0;
        while (m_accepts < target && cyc < 40000) begin
            @(posedge clk);
            #1;
            cyc++;
            start  = ($urandom_range(0, 3) != 0);
            neg_in = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r == 0)      bin = WIDTH'($urandom_range(0, 20));
            else if (r == 1) bin = WIDTH'($urandom_range(9990, 10010));
            else             bin = WIDTH'($urandom_range(0, 16383));
        end
        start = 1'b0;
        n_vec++;
        if (m_accepts < target) begin
            n_fail++;
            $display("FAIL t6_accepts got=%0d required=%0d", m_accepts - (target - 1000), 1000);
        end
        $display("txn t6_random accepted=%0d cycles=%0d", m_accepts - (target - 1000), cyc);
        repeat (WIDTH + 6) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
